ann_day_sequencer: RTL and testbench
====================================

// Module: ann_day_sequencer
// PURPOSE
//  Hardware controller replacing testbench sequencing of the ANN core (TMax predictor). Per day d it:
//  - loads that day's weight set from weight RAM into the ANN
//  - presents temps d..d+3, triggers calculation and emits the prediction
//  - in training mode, presents temp d+4 as Target, pulses training and writes updated weights back to RAM
//  Sits between the temperature/weight RAMs and the ANN instance.
// PARAMETERS
//  WIDTH       156  data/weight word width (INPUT_SIZE*12)
//  NUM_W       40   weights per day set (INPUT_NUM*NEURON_NUM+NEURON_NUM)
//  NUM_DAYS    365  days processed per run (temp RAM holds NUM_DAYS+4 words)
//  AW          14   RAM address width; must be >= clog2(NUM_DAYS*NUM_W)
//  CALC_TO     255  max cycles to wait for Ready_Signal after tb_rev_ready_h
//  TRAIN_WAIT  8    fixed cycles after training_enable_h pulse before readback
// PORTS
//  Clk                in   1      clock
//  Reset_h            in   1      async active-high reset
//  start_h            in   1      1-cycle pulse, starts run (ignored unless IDLE/DONE/ERR)
//  train_mode_h       in   1      sampled at start: 1=train+writeback, 0=predict only
//  abort_h            in   1      return to IDLE next cycle
//  t_addr             out  AW     temp RAM read address
//  t_rd_en            out  1      temp RAM read; data valid 1 cycle later
//  t_rd_data          in   WIDTH  temp RAM read data
//  w_addr             out  AW     weight RAM address = d*NUM_W+k
//  w_rd_en            out  1      weight RAM read; 1-cycle latency
//  w_wr_en            out  1      weight RAM write
//  w_rd_data          in   WIDTH  weight RAM read data
//  w_wr_data          out  WIDTH  weight RAM write data
//  Weight_in          out  WIDTH  to ANN
//  Weight_Save_enable out  1      to ANN: one weight accepted per cycle while high
//  Temperature_in_0..3 out WIDTH  to ANN (4 ports)
//  Target             out  WIDTH  to ANN
//  tb_rev_ready_h     out  1      to ANN: 1-cycle calc trigger
//  training_enable_h  out  1      to ANN: 1-cycle train trigger
//  Weight_Load_enable out  1      to ANN: ANN streams New_weight_out one per cycle
//  Data_out           in   WIDTH  from ANN: prediction
//  New_weight_out     in   WIDTH  from ANN: updated weight stream
//  Ready_Signal       in   1      from ANN: result valid (level)
//  pred_valid         out  1      1-cycle pulse with pred_data/pred_day
//  pred_data          out  WIDTH  raw Data_out captured; scaling is downstream
//  pred_day           out  9      day index d
//  busy, done, err    out  1      status; done/err hold until next start or reset
// BEHAVIOUR
//  - Reset/abort: state=IDLE, counters 0. All outputs 0, except t_addr/w_addr, data regs and
//    Temperature_in_*, which need not be cleared on abort.
//  - FSM:
//    IDLE -start-> LOAD_W  (d=0, k=0)
//    LOAD_W: w_rd_en k=0..NUM_W-1 on consecutive cycles; Weight_in=w_rd_data with
//      Weight_Save_enable=1 on the following cycle. NUM_W+1 cycles, then FETCH_T.
//    FETCH_T: read t_addr d..d+3 into Temperature_in_0..3 and d+4 into Target (6 cycles), then CALC.
//    CALC: pulse tb_rev_ready_h 1 cycle; wait Ready_Signal=1.
//      - timeout after CALC_TO cycles -> ERR
//      - on Ready_Signal: latch Data_out, pulse pred_valid
//      - then TRAIN if train_mode else NEXT.
//    TRAIN: pulse training_enable_h 1 cycle; wait TRAIN_WAIT cycles -> READBACK.
//    READBACK: Weight_Load_enable=1 for NUM_W+1 cycles. From cycle 2 on, w_wr_en=1,
//      w_wr_data=New_weight_out, w_addr=d*NUM_W+j for j=0..NUM_W-1. Then NEXT.
//    NEXT: d==NUM_DAYS-1 ? DONE : d++ -> LOAD_W.
//    DONE/ERR: idle outputs, flag held; start -> LOAD_W.
//  - w_rd_en and w_wr_en are never high in the same cycle.
//  - Ready_Signal already high at trigger is ignored; a fresh 0->1 edge is required.
//  - start while busy: ignored. abort and start in the same cycle: abort wins.
//  - w_addr is a running base (+NUM_W per day), not a multiplier; no wrap below NUM_DAYS*NUM_W.
//  - Per-day latency (train, Ready after L cycles): (NUM_W+1)+6+(L+1)+(TRAIN_WAIT+1)+(NUM_W+1)+1.
// STRUCTURE
//  - ann_pkg: WIDTH, NUM_W, state enum (IDLE, LOAD_W, FETCH_T, CALC, TRAIN, READBACK, NEXT, DONE, ERR).
//  - Sub-module ann_seq_addr_gen: day-base/offset counters producing t_addr and w_addr.
// TESTING
//  - NUM_DAYS=2, train=0, ANN model Ready after 5 cycles ->
//    2 pred_valid with pred_day 0,1; no w_wr_en; done=1.
//  - Weights RAM word=k+1 -> ANN model sees Weight_in 1..40 on 40 consecutive Save-enable cycles.
//  - train=1, model streams New_weight_out = 0x100+j -> RAM words d*40+j hold 0x100+j; day 1 reload reads them.
//  - Temp RAM word=i*10: day 1 -> Temperature_in_0..3=10,20,30,40, Target=50.
//  - Ready_Signal never asserted -> err=1 after CALC_TO cycles, all enables 0.
//  - abort mid-READBACK -> IDLE next cycle, w_wr_en=0; Reset_h mid-LOAD_W -> all outputs 0 immediately.

Source files
------------

// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ann_pkg
// Description : Shared constants, FSM state encoding and a small helper for
//               the ANN day sequencer (ann_day_sequencer / ann_seq_addr_gen).
// Revision    : 1.0 - initial release
// ============================================================================
package ann_pkg;

    // Default word width (INPUT_SIZE*12) and weights per day set.
    localparam int c_WIDTH     = 156;
    localparam int c_NUM_W     = 40;

    // Day index width (pred_day port) and phase counter width.
    localparam int c_DAY_W     = 9;
    localparam int c_CNT_W     = 16;

    // Temperature fetch phase: 5 reads (d..d+4) plus one trailing capture cycle.
    localparam int c_FETCH_LEN = 6;

    // Sequencer states, explicitly encoded.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD_W   = 4'd1,
        S_FETCH_T  = 4'd2,
        S_CALC     = 4'd3,
        S_TRAIN    = 4'd4,
        S_READBACK = 4'd5,
        S_NEXT     = 4'd6,
        S_DONE     = 4'd7,
        S_ERR      = 4'd8
    } state_e;

    // States in which a new run may be started.
    function automatic logic is_idle_like(input state_e s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ann_seq_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ann_seq_addr_gen
// Description : Day-base counters for the ANN day sequencer. Keeps the current
//               day index d and a running weight base d*NUM_W (accumulated,
//               not multiplied), and adds the per-phase offset to form the
//               temperature and weight RAM addresses.
// Ports       : clk, rst       - clock, async active-high reset
//               i_clear        - return to day 0 (start of run / abort)
//               i_advance      - step to next day
//               i_offset       - offset within the current day
//               o_day          - current day index
//               o_t_addr       - temperature RAM address (d + offset)
//               o_w_addr       - weight RAM address (d*NUM_W + offset)
// Revision    : 1.0 - initial release
// ============================================================================
module ann_seq_addr_gen
    import ann_pkg::*;
#(
    parameter int NUM_W = c_NUM_W,
    parameter int AW    = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_advance,
    input  logic [AW-1:0]      i_offset,
    output logic [c_DAY_W-1:0] o_day,
    output logic [AW-1:0]      o_t_addr,
    output logic [AW-1:0]      o_w_addr
);

    logic [c_DAY_W-1:0] r_day;
    logic [AW-1:0]      r_w_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_day    <= '0;
            r_w_base <= '0;
        end else if (i_clear) begin
            r_day    <= '0;
            r_w_base <= '0;
        end else if (i_advance) begin
            r_day    <= r_day + c_DAY_W'(1);
            r_w_base <= r_w_base + AW'(NUM_W);
        end
    end

    assign o_day    = r_day;
    assign o_t_addr = AW'(r_day) + i_offset;
    assign o_w_addr = r_w_base + i_offset;

endmodule
`default_nettype wire

// File: rtl/ann_day_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ann_day_sequencer
// Description : Per-day controller for the ANN TMax predictor. For each day d
//               it loads the day's weight set into the ANN, presents temps
//               d..d+3 (and d+4 as Target), triggers the calculation, emits the
//               prediction and, in training mode, pulses training and writes
//               the updated weights back to the weight RAM.
// Ports       : Clk/Reset_h            - clock, async active-high reset
//               start_h/train_mode_h   - run start pulse / mode sampled at start
//               abort_h                - return to IDLE
//               t_*                    - temperature RAM read port (1-cycle)
//               w_*                    - weight RAM read/write port (1-cycle)
//               Weight_in..Weight_Load_enable - ANN control/data
//               Data_out/New_weight_out/Ready_Signal - ANN results
//               pred_valid/pred_data/pred_day - prediction output
//               busy/done/err          - run status
// Revision    : 1.0 - initial release
// ============================================================================
module ann_day_sequencer
    import ann_pkg::*;
#(
    parameter int WIDTH      = c_WIDTH,
    parameter int NUM_W      = c_NUM_W,
    parameter int NUM_DAYS   = 365,
    parameter int AW         = 14,
    parameter int CALC_TO    = 255,
    parameter int TRAIN_WAIT = 8
) (
    input  logic               Clk,
    input  logic               Reset_h,
    input  logic               start_h,
    input  logic               train_mode_h,
    input  logic               abort_h,
    output logic [AW-1:0]      t_addr,
    output logic               t_rd_en,
    input  logic [WIDTH-1:0]   t_rd_data,
    output logic [AW-1:0]      w_addr,
    output logic               w_rd_en,
    output logic               w_wr_en,
    input  logic [WIDTH-1:0]   w_rd_data,
    output logic [WIDTH-1:0]   w_wr_data,
    output logic [WIDTH-1:0]   Weight_in,
    output logic               Weight_Save_enable,
    output logic [WIDTH-1:0]   Temperature_in_0,
    output logic [WIDTH-1:0]   Temperature_in_1,
    output logic [WIDTH-1:0]   Temperature_in_2,
    output logic [WIDTH-1:0]   Temperature_in_3,
    output logic [WIDTH-1:0]   Target,
    output logic               tb_rev_ready_h,
    output logic               training_enable_h,
    output logic               Weight_Load_enable,
    input  logic [WIDTH-1:0]   Data_out,
    input  logic [WIDTH-1:0]   New_weight_out,
    input  logic               Ready_Signal,
    output logic               pred_valid,
    output logic [WIDTH-1:0]   pred_data,
    output logic [c_DAY_W-1:0] pred_day,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e               r_state;
    state_e               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_train;
    logic                 r_rdy_prev;
    logic [WIDTH-1:0]     r_temp0;
    logic [WIDTH-1:0]     r_temp1;
    logic [WIDTH-1:0]     r_temp2;
    logic [WIDTH-1:0]     r_temp3;
    logic [WIDTH-1:0]     r_target;
    logic                 r_pred_valid;
    logic [WIDTH-1:0]     r_pred_data;
    logic [c_DAY_W-1:0]   r_pred_day;

    logic                 w_start_ok;
    logic                 w_rdy_edge;
    logic                 w_last_day;
    logic                 w_clear;
    logic                 w_advance;
    logic [AW-1:0]        w_offset;
    logic [c_DAY_W-1:0]   w_day;

    assign w_start_ok = start_h & ~abort_h & is_idle_like(r_state);
    // Only a fresh 0->1 edge after the trigger cycle counts; a Ready level left
    // over from the previous calculation must not complete this one.
    assign w_rdy_edge = Ready_Signal & ~r_rdy_prev & (r_cnt != '0);
    assign w_last_day = (w_day == c_DAY_W'(NUM_DAYS - 1));
    assign w_clear    = w_start_ok | abort_h;
    assign w_advance  = (r_state == S_NEXT) & ~w_last_day & ~abort_h;

    ann_seq_addr_gen #(
        .NUM_W (NUM_W),
        .AW    (AW)
    ) u_addr_gen (
        .clk       (Clk),
        .rst       (Reset_h),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_offset  (w_offset),
        .o_day     (w_day),
        .o_t_addr  (t_addr),
        .o_w_addr  (w_addr)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (abort_h) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_h) w_state_next = S_LOAD_W;
                end
                S_LOAD_W: begin
                    if (r_cnt == c_CNT_W'(NUM_W)) w_state_next = S_FETCH_T;
                end
                S_FETCH_T: begin
                    if (r_cnt == c_CNT_W'(c_FETCH_LEN - 1)) w_state_next = S_CALC;
                end
                S_CALC: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (w_rdy_edge)
                        w_state_next = r_train ? S_TRAIN : S_NEXT;
                    else if (r_cnt == c_CNT_W'(CALC_TO - 1))
                        w_state_next = S_ERR;
                end
                S_TRAIN: begin
                    if (r_cnt == c_CNT_W'(TRAIN_WAIT)) w_state_next = S_READBACK;
                end
                S_READBACK: begin
                    if (r_cnt == c_CNT_W'(NUM_W)) w_state_next = S_NEXT;
                end
                S_NEXT: begin
                    w_state_next = w_last_day ? S_DONE : S_LOAD_W;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Phase counter, captured temperatures and prediction registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            r_cnt        <= '0;
            r_train      <= 1'b0;
            r_rdy_prev   <= 1'b0;
            r_temp0      <= '0;
            r_temp1      <= '0;
            r_temp2      <= '0;
            r_temp3      <= '0;
            r_target     <= '0;
            r_pred_valid <= 1'b0;
            r_pred_data  <= '0;
            r_pred_day   <= '0;
        end else begin
            r_rdy_prev   <= Ready_Signal;
            r_pred_valid <= 1'b0;

            // Counter restarts at 0 on every state change.
            if (abort_h || (w_state_next != r_state) || is_idle_like(r_state))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_W'(1);

            if (w_start_ok) r_train <= train_mode_h;

            // Read issued on cycle n lands on cycle n+1.
            if ((r_state == S_FETCH_T) && !abort_h) begin
                if (r_cnt == c_CNT_W'(1)) r_temp0  <= t_rd_data;
                if (r_cnt == c_CNT_W'(2)) r_temp1  <= t_rd_data;
                if (r_cnt == c_CNT_W'(3)) r_temp2  <= t_rd_data;
                if (r_cnt == c_CNT_W'(4)) r_temp3  <= t_rd_data;
                if (r_cnt == c_CNT_W'(5)) r_target <= t_rd_data;
            end

            if ((r_state == S_CALC) && w_rdy_edge && !abort_h) begin
                r_pred_valid <= 1'b1;
                r_pred_data  <= Data_out;
                r_pred_day   <= w_day;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        t_rd_en            = 1'b0;
        w_rd_en            = 1'b0;
        w_wr_en            = 1'b0;
        w_wr_data          = '0;
        Weight_in          = '0;
        Weight_Save_enable = 1'b0;
        tb_rev_ready_h     = 1'b0;
        training_enable_h  = 1'b0;
        Weight_Load_enable = 1'b0;
        w_offset           = '0;
        busy               = ~is_idle_like(r_state);
        done               = (r_state == S_DONE);
        err                = (r_state == S_ERR);
        case (r_state)
            S_LOAD_W: begin
                w_offset = AW'(r_cnt);
                w_rd_en  = (r_cnt < c_CNT_W'(NUM_W));
                // Weight read on cycle k is handed to the ANN on cycle k+1.
                if (r_cnt != '0) begin
                    Weight_Save_enable = 1'b1;
                    Weight_in          = w_rd_data;
                end
            end
            S_FETCH_T: begin
                w_offset = AW'(r_cnt);
                t_rd_en  = (r_cnt < c_CNT_W'(c_FETCH_LEN - 1));
            end
            S_CALC: begin
                tb_rev_ready_h = (r_cnt == '0);
            end
            S_TRAIN: begin
                training_enable_h = (r_cnt == '0);
            end
            S_READBACK: begin
                Weight_Load_enable = 1'b1;
                // The ANN needs one cycle before the first updated weight appears.
                if (r_cnt != '0) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = New_weight_out;
                    w_offset  = AW'(r_cnt - c_CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign Temperature_in_0 = r_temp0;
    assign Temperature_in_1 = r_temp1;
    assign Temperature_in_2 = r_temp2;
    assign Temperature_in_3 = r_temp3;
    assign Target           = r_target;
    assign pred_valid       = r_pred_valid;
    assign pred_data        = r_pred_data;
    assign pred_day         = r_pred_day;

endmodule
`default_nettype wire

// File: tb/tb_ann_day_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ann_day_sequencer
// Description : Self-checking bench for ann_day_sequencer with two-day runs,
//               behavioural temperature/weight RAMs and a small ANN model.
//               Expected responses are queued by the stimulus and consumed by
//               independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ann_day_sequencer;

    localparam int WIDTH    = 156;
    localparam int NUM_W    = 40;
    localparam int NUM_DAYS = 2;
    localparam int AW       = 14;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct packed { logic [8:0] day; logic [WIDTH-1:0] data; } pred_t;
    typedef struct packed { logic [AW-1:0] addr; logic [WIDTH-1:0] data; } wr_t;

    logic          Clk = 1'b0;
    logic          Reset_h = 1'b1;
    logic          start_h = 1'b0;
    logic          train_mode_h = 1'b0;
    logic          abort_h = 1'b0;
    logic [AW-1:0] t_addr, w_addr;
    logic          t_rd_en, w_rd_en, w_wr_en;
    word_t         t_rd_data = '0;
    word_t         w_rd_data = '0;
    word_t         w_wr_data, Weight_in;
    logic          Weight_Save_enable;
    word_t         Temperature_in_0, Temperature_in_1, Temperature_in_2, Temperature_in_3, Target;
    logic          tb_rev_ready_h, training_enable_h, Weight_Load_enable;
    word_t         Data_out = '0;
    word_t         New_weight_out = '0;
    logic          Ready_Signal = 1'b0;
    logic          pred_valid;
    word_t         pred_data;
    logic [8:0]    pred_day;
    logic          busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    word_t save_q[$];
    word_t temp_q[$];
    pred_t pred_q[$];
    wr_t   wr_q[$];

    word_t t_mem [0:15];
    word_t w_mem [0:127];

    logic  no_ready = 1'b0;
    logic  overlap  = 1'b0;
    int    lat      = 0;
    logic  pend     = 1'b0;
    int    nw_cnt   = 0;

    always #5 Clk = ~Clk;

    ann_day_sequencer #(
        .WIDTH(WIDTH), .NUM_W(NUM_W), .NUM_DAYS(NUM_DAYS), .AW(AW),
        .CALC_TO(255), .TRAIN_WAIT(8)
    ) dut (
        .Clk(Clk), .Reset_h(Reset_h), .start_h(start_h), .train_mode_h(train_mode_h),
        .abort_h(abort_h), .t_addr(t_addr), .t_rd_en(t_rd_en), .t_rd_data(t_rd_data),
        .w_addr(w_addr), .w_rd_en(w_rd_en), .w_wr_en(w_wr_en), .w_rd_data(w_rd_data),
        .w_wr_data(w_wr_data), .Weight_in(Weight_in), .Weight_Save_enable(Weight_Save_enable),
        .Temperature_in_0(Temperature_in_0), .Temperature_in_1(Temperature_in_1),
        .Temperature_in_2(Temperature_in_2), .Temperature_in_3(Temperature_in_3),
        .Target(Target), .tb_rev_ready_h(tb_rev_ready_h), .training_enable_h(training_enable_h),
        .Weight_Load_enable(Weight_Load_enable), .Data_out(Data_out),
        .New_weight_out(New_weight_out), .Ready_Signal(Ready_Signal),
        .pred_valid(pred_valid), .pred_data(pred_data), .pred_day(pred_day),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RAMs with one-cycle read latency.
    always @(posedge Clk) begin
        if (t_rd_en) t_rd_data <= t_mem[t_addr[3:0]];
        if (w_rd_en) w_rd_data <= w_mem[w_addr[6:0]];
        if (w_wr_en) w_mem[w_addr[6:0]] <= w_wr_data;
    end

    // ANN model: Ready 5 cycles after trigger (held until next trigger),
    // prediction = T0+T1+T2+T3, updated weights 0x100+j streamed one cycle late.
    always @(posedge Clk) begin
        if (tb_rev_ready_h) begin
            Ready_Signal <= 1'b0;
            lat          <= 1;
            pend         <= !no_ready;
        end else if (pend) begin
            if (lat == 4) begin
                Ready_Signal <= 1'b1;
                pend         <= 1'b0;
                Data_out     <= Temperature_in_0 + Temperature_in_1 + Temperature_in_2 + Temperature_in_3;
            end else begin
                lat <= lat + 1;
            end
        end
        if (Weight_Load_enable) begin
            New_weight_out <= word_t'(32'h100 + nw_cnt);
            nw_cnt         <= nw_cnt + 1;
        end else begin
            nw_cnt <= 0;
        end
    end

    // Monitors
    always @(negedge Clk) begin : mon_save
        word_t e;
        if (Weight_Save_enable) begin
            if (save_q.size() == 0) chk("save_unexpected", 1, 0);
            else begin
                e = save_q.pop_front();
                chk("weight_in", Weight_in, e);
            end
        end
    end

    always @(negedge Clk) begin : mon_temp
        word_t e0, e1, e2, e3, e4;
        if (tb_rev_ready_h) begin
            if (temp_q.size() < 5) chk("temp_unexpected", 1, 0);
            else begin
                e0 = temp_q.pop_front(); e1 = temp_q.pop_front(); e2 = temp_q.pop_front();
                e3 = temp_q.pop_front(); e4 = temp_q.pop_front();
                chk("temp0", Temperature_in_0, e0);
                chk("temp1", Temperature_in_1, e1);
                chk("temp2", Temperature_in_2, e2);
                chk("temp3", Temperature_in_3, e3);
                chk("target", Target, e4);
            end
        end
    end

    always @(negedge Clk) begin : mon_pred
        pred_t e;
        if (pred_valid) begin
            if (pred_q.size() == 0) chk("pred_unexpected", 1, 0);
            else begin
                e = pred_q.pop_front();
                chk("pred_day", pred_day, e.day);
                chk("pred_data", pred_data, e.data);
            end
        end
    end

    always @(negedge Clk) begin : mon_wr
        wr_t e;
        if (w_wr_en) begin
            if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("wr_addr", w_addr, e.addr);
                chk("wr_data", w_wr_data, e.data);
            end
        end
        if (w_rd_en && w_wr_en) overlap = 1'b1;
    end

    // Expectation helpers
    task automatic push_saves(input int base);
        for (int k = 0; k < NUM_W; k++) save_q.push_back(word_t'(base + k));
    endtask

    task automatic push_temps(input int d);
        for (int i = 0; i < 5; i++) temp_q.push_back(word_t'(10 * (d + i)));
    endtask

    task automatic push_pred(input int d, input int v);
        pred_t p;
        p.day  = 9'(d);
        p.data = word_t'(v);
        pred_q.push_back(p);
    endtask

    task automatic push_writes(input int d, input int count);
        wr_t w;
        for (int j = 0; j < count; j++) begin
            w.addr = AW'(d * NUM_W + j);
            w.data = word_t'(32'h100 + j);
            wr_q.push_back(w);
        end
    endtask

    task automatic start_run(input logic tm);
        @(posedge Clk); #1;
        start_h = 1'b1; train_mode_h = tm;
        @(posedge Clk); #1;
        start_h = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int n);
        n = 0;
        while (!(done || err) && n < bound) begin
            @(posedge Clk); n++; #1;
        end
        if (n >= bound) chk("run_end_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 16; i++) t_mem[i] = word_t'(i * 10);
        for (int i = 0; i < 128; i++) w_mem[i] = word_t'((i % NUM_W) + 1);

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ctrl", {t_rd_en, w_rd_en, w_wr_en, Weight_Save_enable, tb_rev_ready_h,
                         training_enable_h, Weight_Load_enable, pred_valid, busy, done, err}, 0);
        chk("rst_addr", {t_addr, w_addr}, 0);
        chk("rst_temps", Temperature_in_0 | Temperature_in_1 | Temperature_in_2 |
                         Temperature_in_3 | Target, 0);
        chk("rst_data", Weight_in | w_wr_data | pred_data | word_t'(pred_day), 0);
        Reset_h = 1'b0;

        // Run A: predict only, weights k+1
        for (int d = 0; d < 2; d++) begin
            push_saves(1);
            push_temps(d);
        end
        push_pred(0, 60);
        push_pred(1, 100);
        start_run(1'b0);
        wait_end(500, n);
        chk("runA_cycles", n, 108);
        chk("runA_status", {done, err, busy}, 3'b100);

        // Run B: training with writeback
        for (int d = 0; d < 2; d++) begin
            push_saves(1);
            push_temps(d);
            push_writes(d, NUM_W);
        end
        push_pred(0, 60);
        push_pred(1, 100);
        start_run(1'b1);
        wait_end(800, n);
        chk("runB_cycles", n, 208);
        chk("runB_status", {done, err, busy}, 3'b100);
        for (int i = 0; i < 2 * NUM_W; i++)
            chk("ram_writeback", w_mem[i], word_t'(32'h100 + (i % NUM_W)));

        // Run C: predict only, reloads the written-back weights
        for (int d = 0; d < 2; d++) begin
            push_saves(32'h100);
            push_temps(d);
        end
        push_pred(0, 60);
        push_pred(1, 100);
        start_run(1'b0);
        wait_end(500, n);
        chk("runC_cycles", n, 108);
        chk("runC_status", {done, err, busy}, 3'b100);

        // Calculation timeout
        no_ready = 1'b1;
        push_saves(32'h100);
        push_temps(0);
        start_run(1'b0);
        wait_end(800, n);
        chk("timeout_cycles", n, 302);
        chk("timeout_status", {done, err, busy}, 3'b010);
        chk("timeout_enables", {t_rd_en, w_rd_en, w_wr_en, Weight_Save_enable, tb_rev_ready_h,
                                training_enable_h, Weight_Load_enable, pred_valid}, 0);
        no_ready = 1'b0;

        // Abort in the middle of readback: exactly 5 writes land
        push_saves(32'h100);
        push_temps(0);
        push_pred(0, 60);
        push_writes(0, 5);
        start_run(1'b1);
        n = 0;
        while (!Weight_Load_enable && n < 300) begin
            @(posedge Clk); n++; #1;
        end
        chk("readback_reached", Weight_Load_enable, 1);
        repeat (5) @(posedge Clk);
        #1 abort_h = 1'b1;
        @(posedge Clk);
        #1 abort_h = 1'b0;
        chk("abort_idle", {busy, w_wr_en, Weight_Load_enable, done, err}, 0);

        // Abort and start in the same cycle: abort wins
        @(posedge Clk);
        #1 begin abort_h = 1'b1; start_h = 1'b1; end
        @(posedge Clk);
        #1 begin abort_h = 1'b0; start_h = 1'b0; end
        chk("abort_beats_start", {busy, w_rd_en}, 0);

        // Reset in the middle of LOAD_W clears outputs immediately
        push_saves(32'h100);
        start_run(1'b0);
        repeat (8) @(posedge Clk);
        #1 Reset_h = 1'b1;
        #1;
        chk("rst_mid_ctrl", {t_rd_en, w_rd_en, w_wr_en, Weight_Save_enable, tb_rev_ready_h,
                             training_enable_h, Weight_Load_enable, pred_valid, busy, done, err}, 0);
        chk("rst_mid_addr", {t_addr, w_addr}, 0);
        chk("rst_mid_weight_in", Weight_in, 0);
        save_q.delete();
        @(posedge Clk);
        #1 Reset_h = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        chk("save_q_drained", save_q.size(), 0);
        chk("temp_q_drained", temp_q.size(), 0);
        chk("pred_q_drained", pred_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_wr_exclusive", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
